// File: rtl/xmit_pkg.sv
// Shared definitions for the xmit scheduler: FSM encoding, length width,
// control-block field positions and the frame-length legality check.
package xmit_pkg;

    localparam int XMIT_LEN_W = 12;

    // Field positions of the two frame lengths inside the 24-bit control block
    localparam int CB_HI_LEN_MSB = 23;
    localparam int CB_HI_LEN_LSB = 12;
    localparam int CB_LO_LEN_MSB = 11;
    localparam int CB_LO_LEN_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        XFER = ST_XFER,
        DROP = ST_DROP,
        GAP  = ST_GAP
    } xmit_state_e;

    function automatic logic len_illegal(input logic [31:0] len, input logic [31:0] max_len);
        return (len == 32'd0) || (len > max_len);
    endfunction

endpackage

// File: rtl/xmit_sched_arb.sv
// Winner select between the two frame queues. With XMIT_STARVE_GUARD_EN
// defined, a registered counter forces a low-priority grant after a run of
// high-priority grants made while low priority was waiting.
module xmit_sched_arb
    import xmit_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic grant_i,
    input  logic hi_avail_i,
    input  logic lo_avail_i,
    output logic win_hi_o
);

`ifdef XMIT_STARVE_GUARD_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            force_lo;

    assign force_lo = lo_avail_i && (starve_q >= SC_W'(STARVE_LIMIT));
    assign win_hi_o = hi_avail_i && !force_lo;

    // Count only high grants that bypassed a waiting low frame
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            if (!win_hi_o || !lo_avail_i) begin
                starve_d = '0;
            end else if (starve_q < SC_W'(STARVE_LIMIT)) begin
                starve_d = starve_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_arb;

    assign win_hi_o   = hi_avail_i;
    assign unused_arb = ^{clk_sys, reset_n, grant_i, lo_avail_i, (STARVE_LIMIT > 0)};
`endif

endmodule

// File: rtl/xmit_sched.sv
// Transmit scheduler: picks a frame queue, reads its bytes toward the phy
// FIFO, drops illegal lengths and enforces the inter-frame gap.
// Optional starvation guard: XMIT_STARVE_GUARD_EN (lives in xmit_sched_arb).
module xmit_sched
    import xmit_pkg::*;
#(
    parameter int LEN_W        = XMIT_LEN_W,
    parameter int MAX_LEN      = 2047,
    parameter int IFG_CYCLES   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             hi_avail,
    input  logic [LEN_W-1:0] hi_len,
    output logic             hi_pop,
    input  logic             lo_avail,
    input  logic [LEN_W-1:0] lo_len,
    output logic             lo_pop,
    input  logic             buf_ready,
    output logic             rd_en,
    output logic             rd_sel,
    output logic             sof,
    output logic             eof,
    output logic             discard,
    output logic             busy
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    xmit_state_e      state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             first_q, first_d;
    logic             rd_sel_q, rd_sel_d;
    logic             hi_pop_q, hi_pop_d;
    logic             lo_pop_q, lo_pop_d;
    logic             discard_q, discard_d;
    logic             busy_q, busy_d;

    logic             grant;
    logic             win_hi;
    logic [LEN_W-1:0] win_len;
    logic             len_bad;

    assign grant = (state_q == IDLE) && (hi_avail || lo_avail);

    xmit_sched_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .grant_i   (grant),
        .hi_avail_i(hi_avail),
        .lo_avail_i(lo_avail),
        .win_hi_o  (win_hi)
    );

    assign win_len = win_hi ? hi_len : lo_len;
    assign len_bad = len_illegal(32'(win_len), 32'(MAX_LEN));

    // Byte strobes follow buf_ready directly so a stall costs no extra cycle
    assign rd_en = (state_q == XFER) && buf_ready;
    assign sof   = rd_en && first_q;
    assign eof   = rd_en && (cnt_q == LEN_W'(1));

    assign hi_pop  = hi_pop_q;
    assign lo_pop  = lo_pop_q;
    assign discard = discard_q;
    assign rd_sel  = rd_sel_q;
    assign busy    = busy_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        first_d   = first_q;
        rd_sel_d  = rd_sel_q;
        hi_pop_d  = 1'b0;
        lo_pop_d  = 1'b0;
        discard_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    rd_sel_d = win_hi;
                    cnt_d    = win_len;
                    first_d  = 1'b1;
                    hi_pop_d = win_hi;
                    lo_pop_d = !win_hi;
                    if (len_bad) begin
                        state_d   = DROP;
                        discard_d = 1'b1;
                    end else begin
                        state_d = XFER;
                    end
                end
            end
            DROP: begin
                state_d = IDLE;
            end
            XFER: begin
                if (rd_en) begin
                    cnt_d   = cnt_q - LEN_W'(1);
                    first_d = 1'b0;
                    if (cnt_q == LEN_W'(1)) begin
                        if (IFG_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_W'(IFG_CYCLES - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            first_q   <= 1'b0;
            rd_sel_q  <= 1'b0;
            hi_pop_q  <= 1'b0;
            lo_pop_q  <= 1'b0;
            discard_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            rd_sel_q  <= rd_sel_d;
            hi_pop_q  <= hi_pop_d;
            lo_pop_q  <= lo_pop_d;
            discard_q <= discard_d;
            busy_q    <= busy_d;
        end
    end

    // Counters are always loaded before they are read, so they carry no reset
    always_ff @(posedge clk_sys) begin
        cnt_q <= cnt_d;
        gap_q <= gap_d;
    end

endmodule

// File: tb/tb_xmit_sched.sv
// Directed bench for xmit_sched: per-cycle vector table plus hand-written
// sequences for arbitration fairness, stalls and mid-frame reset.
module tb_xmit_sched;

    logic        clk_sys;
    logic        reset_n;
    logic        hi_avail;
    logic [11:0] hi_len;
    logic        hi_pop;
    logic        lo_avail;
    logic [11:0] lo_len;
    logic        lo_pop;
    logic        buf_ready;
    logic        rd_en;
    logic        rd_sel;
    logic        sof;
    logic        eof;
    logic        discard;
    logic        busy;

    int checks;
    int errors;

    xmit_sched dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .hi_avail (hi_avail),
        .hi_len   (hi_len),
        .hi_pop   (hi_pop),
        .lo_avail (lo_avail),
        .lo_len   (lo_len),
        .lo_pop   (lo_pop),
        .buf_ready(buf_ready),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .sof      (sof),
        .eof      (eof),
        .discard  (discard),
        .busy     (busy)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Output bundle order: {hi_pop, lo_pop, rd_en, rd_sel, sof, eof, discard, busy}
    typedef struct {
        string       nm;
        logic        ha;
        logic [11:0] hl;
        logic        la;
        logic [11:0] ll;
        logic        br;
        logic [7:0]  ex;
    } vec_t;

    vec_t vecs[64];
    int   n_vec;

    function automatic logic [7:0] outs();
        return {hi_pop, lo_pop, rd_en, rd_sel, sof, eof, discard, busy};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic ha, input logic [11:0] hl,
                        input logic la, input logic [11:0] ll, input logic br,
                        input logic [7:0] ex);
        vecs[n_vec].nm = nm;
        vecs[n_vec].ha = ha;
        vecs[n_vec].hl = hl;
        vecs[n_vec].la = la;
        vecs[n_vec].ll = ll;
        vecs[n_vec].br = br;
        vecs[n_vec].ex = ex;
        n_vec++;
    endtask

    task automatic next_cycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_idle(input string nm, input int limit);
        int c;
        c = 0;
        while (busy && c < limit) begin
            next_cycle();
            c++;
        end
        check(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  rd_cnt;
        int  sof_cnt;
        int  stall_bad;
        int  eof_k;
        int  eof_at;
        int  bad;
        int  found;
        logic exp_hi;

        checks    = 0;
        errors    = 0;
        n_vec     = 0;
        reset_n   = 1'b0;
        hi_avail  = 1'b0;
        hi_len    = '0;
        lo_avail  = 1'b0;
        lo_len    = '0;
        buf_ready = 1'b0;

        #2;
        check("reset_outs", 32'(outs()), 32'd0);
        #20;
        reset_n = 1'b1;
        next_cycle();

        // Frame of 4 bytes, with hi_avail raised mid-gap to show it is ignored
        push("t1_arb", 1'b1, 12'd4, 1'b0, 12'd0, 1'b1, 8'b0000_0000);
        push("t1_sof", 1'b0, 12'd4, 1'b0, 12'd0, 1'b1, 8'b1011_1001);
        push("t1_b2",  1'b0, 12'd4, 1'b0, 12'd0, 1'b1, 8'b0011_0001);
        push("t1_b3",  1'b0, 12'd4, 1'b0, 12'd0, 1'b1, 8'b0011_0001);
        push("t1_eof", 1'b0, 12'd4, 1'b0, 12'd0, 1'b1, 8'b0011_0101);
        for (int g = 0; g < 12; g++)
            push("t1_gap", (g == 5), 12'd4, 1'b0, 12'd0, 1'b1, 8'b0001_0001);
        push("t1_idle", 1'b0, 12'd4, 1'b0, 12'd0, 1'b1, 8'b0001_0000);
        // Single-byte frame
        push("t6_arb", 1'b1, 12'd1, 1'b0, 12'd0, 1'b1, 8'b0001_0000);
        push("t6_one", 1'b0, 12'd1, 1'b0, 12'd0, 1'b1, 8'b1011_1101);
        for (int g = 0; g < 12; g++)
            push("t6_gap", 1'b0, 12'd1, 1'b0, 12'd0, 1'b1, 8'b0001_0001);
        push("t6_idle", 1'b0, 12'd1, 1'b0, 12'd0, 1'b1, 8'b0001_0000);
        // Illegal lengths: high zero-length beats a waiting low, then low 0 and 2048
        push("t4_arb_h",  1'b1, 12'd0, 1'b1, 12'd5,    1'b1, 8'b0001_0000);
        push("t4_drop_h", 1'b0, 12'd0, 1'b0, 12'd5,    1'b1, 8'b1001_0011);
        push("t4_idle_h", 1'b0, 12'd0, 1'b0, 12'd5,    1'b1, 8'b0001_0000);
        push("t4_arb0",   1'b0, 12'd0, 1'b1, 12'd0,    1'b1, 8'b0001_0000);
        push("t4_drop0",  1'b0, 12'd0, 1'b0, 12'd0,    1'b1, 8'b0100_0011);
        push("t4_idle0",  1'b0, 12'd0, 1'b0, 12'd0,    1'b1, 8'b0000_0000);
        push("t4_arb1",   1'b0, 12'd0, 1'b1, 12'd2048, 1'b1, 8'b0000_0000);
        push("t4_drop1",  1'b0, 12'd0, 1'b0, 12'd2048, 1'b1, 8'b0100_0011);
        push("t4_idle1",  1'b0, 12'd0, 1'b0, 12'd2048, 1'b1, 8'b0000_0000);

        for (int i = 0; i < n_vec; i++) begin
            hi_avail  = vecs[i].ha;
            hi_len    = vecs[i].hl;
            lo_avail  = vecs[i].la;
            lo_len    = vecs[i].ll;
            buf_ready = vecs[i].br;
            @(negedge clk_sys);
            check(vecs[i].nm, 32'(outs()), 32'(vecs[i].ex));
            next_cycle();
        end

        // Both queues always ready, 8-byte frames
        hi_avail  = 1'b1;
        lo_avail  = 1'b1;
        hi_len    = 12'd8;
        lo_len    = 12'd8;
        buf_ready = 1'b1;
        for (int f = 0; f < 10; f++) begin
            found = 0;
            for (int c = 0; c < 40 && found == 0; c++) begin
                @(negedge clk_sys);
                if (hi_pop || lo_pop) found = 1;
                else next_cycle();
            end
`ifdef XMIT_STARVE_GUARD_EN
            exp_hi = ((f % 5) != 4);
`else
            exp_hi = 1'b1;
`endif
            if (found == 0) begin
                check("t2_timeout", 32'd0, 32'd1);
            end else begin
                check("t2_grant", 32'({hi_pop, lo_pop}), 32'({exp_hi, !exp_hi}));
                check("t2_rd_sel", 32'(rd_sel), 32'(exp_hi));
            end
            next_cycle();
        end
        hi_avail = 1'b0;
        lo_avail = 1'b0;
        wait_idle("t2_idle", 40);

        // 512-byte frame with buf_ready toggling every cycle
        hi_avail = 1'b1;
        hi_len   = 12'd512;
        next_cycle();
        hi_avail  = 1'b0;
        rd_cnt    = 0;
        sof_cnt   = 0;
        stall_bad = 0;
        eof_k     = 0;
        eof_at    = 0;
        for (int k = 1; k <= 1100 && eof_k == 0; k++) begin
            buf_ready = k[0];
            @(negedge clk_sys);
            if (rd_en) rd_cnt++;
            if (sof) sof_cnt++;
            if (rd_en != buf_ready || !rd_sel) stall_bad++;
            if (eof) begin
                eof_k  = k;
                eof_at = rd_cnt;
            end
            next_cycle();
        end
        check("t3_rd_count", 32'(rd_cnt), 32'd512);
        check("t3_eof_byte", 32'(eof_at), 32'd512);
        check("t3_xfer_len", 32'(eof_k), 32'd1023);
        check("t3_sof_count", 32'(sof_cnt), 32'd1);
        check("t3_stall", 32'(stall_bad), 32'd0);
        check("t3_gap_busy", 32'(busy), 32'd1);
        buf_ready = 1'b1;
        wait_idle("t3_idle", 40);

        // Reset at the 100th byte of a 512-byte frame
        hi_avail = 1'b1;
        hi_len   = 12'd512;
        next_cycle();
        hi_avail = 1'b0;
        for (int k = 1; k < 100; k++) next_cycle();
        check("t5_pre_rd", 32'({rd_en, busy}), 32'b11);
        reset_n = 1'b0;
        #1;
        check("t5_reset_outs", 32'(outs()), 32'd0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        next_cycle();
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_sys);
            if (outs() != 8'd0) bad++;
            next_cycle();
        end
        check("t5_no_replay", 32'(bad), 32'd0);
        hi_avail = 1'b1;
        hi_len   = 12'd1;
        next_cycle();
        hi_avail = 1'b0;
        @(negedge clk_sys);
        check("t5_restart", 32'(outs()), 32'(8'b1011_1101));
        next_cycle();
        wait_idle("t5_idle", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xmit_sched.md
# xmit_sched

Transmit scheduler for the xmit path, running in the `clk_sys` domain. It arbitrates between the high- and low-priority frame queues and sequences the byte reads from the selected data buffer toward the phy-side FIFO. It also enforces an inter-frame gap and drops frames whose control-block length is illegal.

## Interface
- `LEN_W`, 12: width of frame-length fields, taken from the 24-bit control block.
- `MAX_LEN`, 2047: largest legal frame length in bytes.
- `IFG_CYCLES`, 12: idle `clk_sys` cycles inserted after each transmitted frame.
- `STARVE_LIMIT`, 4: consecutive high-priority grants allowed while a low-priority frame waits. Used only with the starvation guard.

Ports:
- `clk_sys` in 1: the single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hi_avail` in 1: high-priority control queue is non-empty.
- `hi_len` in `LEN_W`: head-of-queue frame length, high priority.
- `hi_pop` out 1: one-cycle pulse that pops the high-priority control queue.
- `lo_avail` in 1: low-priority control queue is non-empty.
- `lo_len` in `LEN_W`: head-of-queue frame length, low priority.
- `lo_pop` out 1: one-cycle pulse that pops the low-priority control queue.
- `buf_ready` in 1: downstream phy FIFO can accept one byte this cycle.
- `rd_en` out 1: read one byte from the selected data buffer.
- `rd_sel` out 1: selects the data buffer; 1 = high priority, 0 = low priority.
- `sof` out 1: asserted with the first `rd_en` of a frame.
- `eof` out 1: asserted with the last `rd_en` of a frame.
- `discard` out 1: one-cycle pulse when a head frame is dropped.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States:
  - IDLE: no frame in progress.
  - XFER: reading frame bytes.
  - DROP: dropping an illegal frame; lasts one cycle.
  - GAP: inter-frame gap.
- Arbitration happens only in IDLE, on the cycle that sees any `*_avail`=1.
  - Winner: high priority, unless the starvation guard forces low (see Configuration).
  - The winner's length, `rd_sel`, and next state are latched at that edge.
- Illegal length (`len`==0 or `len`>`MAX_LEN`) → go to DROP.
  - In DROP: pop the winning queue, pulse `discard`, no `rd_en`, then return to IDLE.
  - The receive side writes no data for such frames, so there is nothing to flush.
- Legal length → go to XFER.
  - The winning queue's `*_pop` pulses in the first XFER cycle.
  - The byte counter is loaded with the latched length.
- In XFER:
  - `rd_en` = `buf_ready`.
  - The counter decrements on each `rd_en`.
  - `sof` = `rd_en` and this is the first byte.
  - `eof` = `rd_en` and counter==1.
  - After the `eof` cycle, go to GAP if `IFG_CYCLES`>0, otherwise to IDLE.
- In GAP: count `IFG_CYCLES` cycles, then return to IDLE. The `*_avail` inputs are ignored.
- `rd_sel` holds its value from the latch point through the end of GAP.
- Counter width is `LEN_W`; the counter never underflows because `len`≥1 is guaranteed in XFER.

## Timing
- Reset values: every output is 0, state is IDLE, the starvation counter is 0.
- Reset is asynchronous and takes effect immediately, including mid-XFER.
  - No pop is replayed after reset.
  - The partially read frame is abandoned.
- Latency: `*_avail` high in IDLE at cycle 0 → `*_pop` and the first possible `rd_en` at cycle 1.
- `rd_en`, `sof`, and `eof` are combinational from the registered state/counter and `buf_ready`. All other outputs are registered.
- `buf_ready`=0 stalls XFER indefinitely with no loss; `sof`/`eof` are deferred to the next accepted byte.
- A frame of length 1 asserts `sof` and `eof` in the same cycle.
- Minimum spacing between `sof` pulses = `len` + `IFG_CYCLES` + 1 cycles.
- Changes on `*_avail`/`*_len` outside IDLE have no effect.

## Configuration
- `XMIT_STARVE_GUARD_EN`
  - Defined:
    - A counter tracks consecutive high-priority grants made while `lo_avail`=1.
    - When the counter reaches `STARVE_LIMIT` and `lo_avail`=1, low priority wins even if `hi_avail`=1.
    - The counter clears on any low-priority grant, or on a high-priority grant made with `lo_avail`=0.
    - DROP grants count like any other grant.
  - Undefined: strict priority, with high always winning; the counter logic is not compiled.

## Structure
- Shared `xmit_pkg` holds:
  - The state enum.
  - `LEN_W`.
  - Control-block field positions: length in [23:12] and [11:0].
- One sub-module, `xmit_sched_arb`: winner select plus the starvation counter. It is combinational select with a registered counter, and owns all `XMIT_STARVE_GUARD_EN` logic.

## Test plan
1. `hi_avail`=1, `hi_len`=4, `buf_ready`=1 → `hi_pop` at cycle 1; `rd_en` cycles 1–4 with `rd_sel`=1; `sof` at cycle 1, `eof` at cycle 4; `busy` through 12 GAP cycles; IDLE at cycle 17.
2. Both queues always available, lengths 8, macro defined → 4 high-priority frames, then 1 low-priority frame, repeating. Macro undefined → high-priority frames only.
3. `hi_len`=512, `buf_ready` toggling 1/0 each cycle → exactly 512 `rd_en`; `eof` on the 512th; XFER lasts 1023 cycles.
4. `lo_len`=0, `hi_avail`=0 → `lo_pop` and `discard` pulse together at cycle 1, no `rd_en`, IDLE at cycle 2. Repeat with `lo_len`=2048 → same response.
5. `reset_n` low at the 100th byte of a 512-byte frame → all outputs 0 in the same cycle; after release, no pop until `*_avail` is sampled in IDLE.
6. `hi_len`=1 → `sof`=`eof`=`rd_en`=1 in a single cycle, then GAP.
